// File: rtl/decode_stage.sv
// THCO-MIPS decode stage: instruction decode, prioritised operand forwarding,
// in-decode branch resolution with delay-slot tracking, load-use interlock.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FWD_N  = 2,
  parameter int ALU_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // Both sides move a beat on a cycle where valid && ready; a producer keeps
  // valid and data stable until accepted; ready never depends on valid.
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               inst_i,
  input  logic [DATA_W-1:0]         inst_addr_i,
  output logic                      rd1_en,
  output logic                      rd2_en,
  output logic [REG_AW-1:0]         rd1_addr,
  output logic [REG_AW-1:0]         rd2_addr,
  input  logic [DATA_W-1:0]         rd1_data,
  input  logic [DATA_W-1:0]         rd2_data,
  input  logic [FWD_N-1:0]          fwd_we,
  input  logic [FWD_N*REG_AW-1:0]   fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]   fwd_data,
  input  logic                      ex_load_i,
  output logic                      jump_o,
  output logic [DATA_W-1:0]         jump_target_o,
  output logic                      illegal_o,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ALU_W-1:0]          alu_op_o,
  output logic [DATA_W-1:0]         op1_o,
  output logic [DATA_W-1:0]         op2_o,
  output logic [DATA_W-1:0]         store_data_o,
  output logic                      mem_rd_o,
  output logic                      mem_wr_o,
  output logic                      wreg_o,
  output logic [REG_AW-1:0]         waddr_o,
  output logic                      ds_q_o
);

  localparam logic [ALU_W-1:0] ALU_NOP = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_NOT = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_SRA = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_CMP = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_MOV = ALU_W'(10);

  localparam logic [REG_AW-1:0] REG_T  = REG_AW'(8);
  localparam logic [REG_AW-1:0] REG_SP = REG_AW'(9);
  localparam logic [REG_AW-1:0] REG_IH = REG_AW'(10);
  localparam logic [REG_AW-1:0] REG_RA = REG_AW'(11);

  localparam logic [4:0] OPC_NOP    = 5'b00001;
  localparam logic [4:0] OPC_B      = 5'b00010;
  localparam logic [4:0] OPC_BEQZ   = 5'b00100;
  localparam logic [4:0] OPC_BNEZ   = 5'b00101;
  localparam logic [4:0] OPC_SHIFT  = 5'b00110;
  localparam logic [4:0] OPC_ADDIU3 = 5'b01000;
  localparam logic [4:0] OPC_ADDIU  = 5'b01001;
  localparam logic [4:0] OPC_SLTI   = 5'b01010;
  localparam logic [4:0] OPC_SP     = 5'b01100;
  localparam logic [4:0] OPC_LI     = 5'b01101;
  localparam logic [4:0] OPC_CMPI   = 5'b01110;
  localparam logic [4:0] OPC_LW     = 5'b10011;
  localparam logic [4:0] OPC_SW     = 5'b11011;
  localparam logic [4:0] OPC_RRR    = 5'b11100;
  localparam logic [4:0] OPC_RR     = 5'b11101;
  localparam logic [4:0] OPC_IH     = 5'b11110;

  typedef enum logic [2:0] {OP1_ZERO, OP1_RS1, OP1_IMM, OP1_PC, OP1_LINK} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_e;
  typedef enum logic [2:0] {BR_NONE, BR_UNCOND, BR_EQZ, BR_NEZ, BR_REG} br_kind_e;

  function automatic logic [DATA_W-1:0] f_resolve(
    input logic                    en,
    input logic [REG_AW-1:0]       addr,
    input logic [DATA_W-1:0]       rdata,
    input logic [FWD_N-1:0]        we,
    input logic [FWD_N*REG_AW-1:0] faddr,
    input logic [FWD_N*DATA_W-1:0] fdata
  );
    logic [DATA_W-1:0] v;
    v = rdata;
    // Walk oldest to youngest so the lowest matching index wins.
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (we[i] && (faddr[i*REG_AW +: REG_AW] == addr)) v = fdata[i*DATA_W +: DATA_W];
    end
    if (!en) v = '0;
    return v;
  endfunction

  logic [4:0]        w_opc;
  logic [2:0]        w_rx, w_ry, w_rz;
  logic [DATA_W-1:0] w_sext4, w_sext5, w_sext8, w_sext11, w_zext8, w_shamt;
  logic              w_rd1_en, w_rd2_en;
  logic [REG_AW-1:0] w_rd1_addr, w_rd2_addr;
  op1_sel_e          w_op1_sel;
  op2_sel_e          w_op2_sel;
  br_kind_e          w_br;
  logic [DATA_W-1:0] w_imm;
  logic [ALU_W-1:0]  w_alu;
  logic              w_wreg, w_mem_rd, w_mem_wr, w_illegal;
  logic [REG_AW-1:0] w_waddr;

  assign w_opc    = inst_i[15:11];
  assign w_rx     = inst_i[10:8];
  assign w_ry     = inst_i[7:5];
  assign w_rz     = inst_i[4:2];
  assign w_sext4  = {{(DATA_W-4){inst_i[3]}}, inst_i[3:0]};
  assign w_sext5  = {{(DATA_W-5){inst_i[4]}}, inst_i[4:0]};
  assign w_sext8  = {{(DATA_W-8){inst_i[7]}}, inst_i[7:0]};
  assign w_sext11 = {{(DATA_W-11){inst_i[10]}}, inst_i[10:0]};
  assign w_zext8  = {{(DATA_W-8){1'b0}}, inst_i[7:0]};
  assign w_shamt  = (inst_i[4:2] == 3'd0) ? DATA_W'(8) : DATA_W'(inst_i[4:2]);

  always_comb begin
    w_rd1_en   = 1'b0;
    w_rd1_addr = '0;
    w_rd2_en   = 1'b0;
    w_rd2_addr = '0;
    w_op1_sel  = OP1_ZERO;
    w_op2_sel  = OP2_ZERO;
    w_imm      = '0;
    w_alu      = ALU_NOP;
    w_wreg     = 1'b0;
    w_waddr    = '0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_br       = BR_NONE;
    w_illegal  = 1'b0;
    unique case (w_opc)
      OPC_NOP: w_illegal = (inst_i[10:0] != 11'd0);
      OPC_B: begin
        w_imm = w_sext11; w_br = BR_UNCOND;
      end
      OPC_BEQZ, OPC_BNEZ: begin
        w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx); w_imm = w_sext8;
        w_br = (w_opc == OPC_BEQZ) ? BR_EQZ : BR_NEZ;
      end
      OPC_SHIFT: begin
        if (inst_i[1:0] == 2'b00 || inst_i[1:0] == 2'b11) begin
          w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_ry);
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; w_imm = w_shamt;
          w_alu = inst_i[0] ? ALU_SRA : ALU_SLL;
          w_wreg = 1'b1; w_waddr = REG_AW'(w_rx);
        end else w_illegal = 1'b1;
      end
      OPC_ADDIU3: begin
        if (!inst_i[4]) begin
          w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx);
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; w_imm = w_sext4; w_alu = ALU_ADD;
          w_wreg = 1'b1; w_waddr = REG_AW'(w_ry);
        end else w_illegal = 1'b1;
      end
      OPC_ADDIU, OPC_SLTI, OPC_CMPI: begin
        w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx);
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; w_imm = w_sext8; w_wreg = 1'b1;
        w_alu   = (w_opc == OPC_ADDIU) ? ALU_ADD : (w_opc == OPC_SLTI) ? ALU_SLT : ALU_CMP;
        w_waddr = (w_opc == OPC_ADDIU) ? REG_AW'(w_rx) : REG_T;
      end
      OPC_SP: begin
        case (w_rx)
          3'b000: begin
            w_rd1_en = 1'b1; w_rd1_addr = REG_T; w_imm = w_sext8; w_br = BR_EQZ;
          end
          3'b100: begin
            if (inst_i[4:0] == 5'd0) begin
              w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_ry);
              w_op1_sel = OP1_RS1; w_alu = ALU_MOV; w_wreg = 1'b1; w_waddr = REG_SP;
            end else w_illegal = 1'b1;
          end
          3'b011: begin
            w_rd1_en = 1'b1; w_rd1_addr = REG_SP;
            w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; w_imm = w_sext8; w_alu = ALU_ADD;
            w_wreg = 1'b1; w_waddr = REG_SP;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LI: begin
        w_op1_sel = OP1_IMM; w_imm = w_zext8; w_alu = ALU_MOV;
        w_wreg = 1'b1; w_waddr = REG_AW'(w_rx);
      end
      OPC_LW, OPC_SW: begin
        w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx);
        w_op1_sel = OP1_RS1; w_op2_sel = OP2_IMM; w_imm = w_sext5; w_alu = ALU_ADD;
        if (w_opc == OPC_LW) begin
          w_mem_rd = 1'b1; w_wreg = 1'b1; w_waddr = REG_AW'(w_ry);
        end else begin
          w_mem_wr = 1'b1; w_rd2_en = 1'b1; w_rd2_addr = REG_AW'(w_ry);
        end
      end
      OPC_RRR: begin
        if (inst_i[0]) begin
          w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx);
          w_rd2_en = 1'b1; w_rd2_addr = REG_AW'(w_ry);
          w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2;
          w_alu = inst_i[1] ? ALU_SUB : ALU_ADD;
          w_wreg = 1'b1; w_waddr = REG_AW'(w_rz);
        end else w_illegal = 1'b1;
      end
      OPC_RR: begin
        case (inst_i[4:0])
          5'b01100, 5'b01101, 5'b01010: begin
            w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx);
            w_rd2_en = 1'b1; w_rd2_addr = REG_AW'(w_ry);
            w_op1_sel = OP1_RS1; w_op2_sel = OP2_RS2; w_wreg = 1'b1;
            w_alu   = (inst_i[4:0] == 5'b01100) ? ALU_AND :
                      (inst_i[4:0] == 5'b01101) ? ALU_OR : ALU_CMP;
            w_waddr = (inst_i[4:0] == 5'b01010) ? REG_T : REG_AW'(w_rx);
          end
          5'b01111: begin
            w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_ry);
            w_op1_sel = OP1_RS1; w_alu = ALU_NOT; w_wreg = 1'b1; w_waddr = REG_AW'(w_rx);
          end
          5'b00000: begin
            case (w_ry)
              3'b000: begin
                w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx); w_br = BR_REG;
              end
              3'b110: begin
                w_rd1_en = 1'b1; w_rd1_addr = REG_AW'(w_rx); w_br = BR_REG;
                w_op1_sel = OP1_LINK; w_alu = ALU_MOV; w_wreg = 1'b1; w_waddr = REG_RA;
              end
              3'b010: begin
                w_op1_sel = OP1_PC; w_alu = ALU_MOV; w_wreg = 1'b1; w_waddr = REG_AW'(w_rx);
              end
              3'b001: begin
                w_rd1_en = 1'b1; w_rd1_addr = REG_RA; w_br = BR_REG;
              end
              default: w_illegal = 1'b1;
            endcase
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_IH: begin
        if (inst_i[7:1] == 7'd0) begin
          w_rd1_en = 1'b1; w_op1_sel = OP1_RS1; w_alu = ALU_MOV; w_wreg = 1'b1;
          w_rd1_addr = inst_i[0] ? REG_AW'(w_rx) : REG_IH;
          w_waddr    = inst_i[0] ? REG_IH : REG_AW'(w_rx);
        end else w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] w_rs1, w_rs2, w_op1, w_op2, w_target;
  logic              w_taken, w_stall, w_accept;

  assign w_rs1 = f_resolve(w_rd1_en, w_rd1_addr, rd1_data, fwd_we, fwd_addr, fwd_data);
  assign w_rs2 = f_resolve(w_rd2_en, w_rd2_addr, rd2_data, fwd_we, fwd_addr, fwd_data);

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    case (w_op1_sel)
      OP1_RS1:  w_op1 = w_rs1;
      OP1_IMM:  w_op1 = w_imm;
      OP1_PC:   w_op1 = inst_addr_i;
      OP1_LINK: w_op1 = inst_addr_i + DATA_W'(1);
      default:  w_op1 = '0;
    endcase
    case (w_op2_sel)
      OP2_RS2: w_op2 = w_rs2;
      OP2_IMM: w_op2 = w_imm;
      default: w_op2 = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_br)
      BR_UNCOND, BR_REG: w_taken = 1'b1;
      BR_EQZ:            w_taken = (w_rs1 == '0);
      BR_NEZ:            w_taken = (w_rs1 != '0);
      default:           w_taken = 1'b0;
    endcase
  end
  assign w_target = (w_br == BR_REG) ? w_rs1 : inst_addr_i + w_imm;

  // Source 0 holds a load whose data only exists after MEM: wait one cycle.
  assign w_stall = ex_load_i && fwd_we[0] &&
                   ((w_rd1_en && fwd_addr[REG_AW-1:0] == w_rd1_addr) ||
                    (w_rd2_en && fwd_addr[REG_AW-1:0] == w_rd2_addr));

  logic              r_out_valid, r_illegal, r_ds, r_mem_rd, r_mem_wr, r_wreg;
  logic [ALU_W-1:0]  r_alu_op;
  logic [DATA_W-1:0] r_op1, r_op2, r_store;
  logic [REG_AW-1:0] r_waddr;

  assign in_ready      = !w_stall && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign jump_o        = w_accept && w_taken && !r_ds;
  assign jump_target_o = jump_o ? w_target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_ds        <= 1'b0;
      r_alu_op    <= ALU_NOP;
      r_op1       <= '0;
      r_op2       <= '0;
      r_store     <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_wreg      <= 1'b0;
      r_waddr     <= '0;
    end else begin
      r_illegal <= w_accept && w_illegal;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        // A transfer sitting in a delay slot does not open a new one.
        r_ds        <= (w_br != BR_NONE) && !r_ds;
        r_alu_op    <= w_alu;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_store     <= w_rs2;
        r_mem_rd    <= w_mem_rd;
        r_mem_wr    <= w_mem_wr;
        r_wreg      <= w_wreg;
        r_waddr     <= w_waddr;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign rd1_en       = w_rd1_en;
  assign rd2_en       = w_rd2_en;
  assign rd1_addr     = w_rd1_addr;
  assign rd2_addr     = w_rd2_addr;
  assign illegal_o    = r_illegal;
  assign out_valid    = r_out_valid;
  assign alu_op_o     = r_alu_op;
  assign op1_o        = r_op1;
  assign op2_o        = r_op2;
  assign store_data_o = r_store;
  assign mem_rd_o     = r_mem_rd;
  assign mem_wr_o     = r_mem_wr;
  assign wreg_o       = r_wreg;
  assign waddr_o      = r_waddr;
  assign ds_q_o       = r_ds;

endmodule
